mem_access_stage: RTL and testbench

//  Memory-access pipeline stage directly downstream of the Execute stage in the hybrid ARM/MIPS core.

---
 rtl/hybrid_pkg.sv | 38 +++
 rtl/exmem_reg.sv | 53 +++++
 rtl/mem_access_stage.sv | 210 +++++++++++++++++++++
 tb/tb_mem_access_stage.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hybrid_pkg.sv
// Shared types for the hybrid ARM/MIPS core memory stage.
//   mem_to_reg_e : write-back result select
//   mem_state_t  : data-memory access FSM state
//   exmem_t      : control half of the EX/MEM pipeline register
// Helper functions classify a latched op as a data-memory load or store.
package hybrid_pkg;

  typedef enum logic [1:0] {
    MTR_LOAD = 2'b00,
    MTR_ALU  = 2'b01,
    MTR_IO   = 2'b10,
    MTR_RSVD = 2'b11
  } mem_to_reg_e;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } mem_state_t;

  typedef struct packed {
    logic        reg_write;
    logic        mem_write;
    logic        mem_pwrite;
    logic        io_flag;
    mem_to_reg_e mem_to_reg;
  } exmem_t;

  // Register-writing op that takes its result from data memory.
  function automatic logic is_load(input exmem_t c);
    return c.reg_write & (c.mem_to_reg == MTR_LOAD) & ~c.io_flag;
  endfunction

  // IO-space writes go to io_we, never to data memory.
  function automatic logic is_store(input exmem_t c);
    return c.mem_write & ~c.io_flag;
  endfunction

endpackage

// File: rtl/exmem_reg.sv
// EX/MEM pipeline register: enable-gated capture of the Execute outputs.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   i_en         capture enable (low while the stage is stalled)
//   i_ctrl       control fields from Execute
//   i_alu        ALU result / address from Execute
//   i_wdata      store data from Execute
//   i_rd         destination register from Execute
//   o_*          latched copies of the above
module exmem_reg
  import hybrid_pkg::*;
#(
  parameter int unsigned DW = 32,
  parameter int unsigned RW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_en,
  input  exmem_t        i_ctrl,
  input  logic [DW-1:0] i_alu,
  input  logic [DW-1:0] i_wdata,
  input  logic [RW-1:0] i_rd,
  output exmem_t        o_ctrl,
  output logic [DW-1:0] o_alu,
  output logic [DW-1:0] o_wdata,
  output logic [RW-1:0] o_rd
);

  exmem_t        r_ctrl;
  logic [DW-1:0] r_alu;
  logic [DW-1:0] r_wdata;
  logic [RW-1:0] r_rd;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ctrl  <= '0;
      r_alu   <= '0;
      r_wdata <= '0;
      r_rd    <= '0;
    end else if (i_en) begin
      r_ctrl  <= i_ctrl;
      r_alu   <= i_alu;
      r_wdata <= i_wdata;
      r_rd    <= i_rd;
    end
  end

  assign o_ctrl  = r_ctrl;
  assign o_alu   = r_alu;
  assign o_wdata = r_wdata;
  assign o_rd    = r_rd;

endmodule

// File: rtl/mem_access_stage.sv
// Memory-access pipeline stage downstream of Execute.
// Latches Execute outputs, runs data-memory loads/stores over a req/ready
// handshake with a bounded wait, issues single-cycle pixel and IO writes,
// and drives the MEM/WB register. Stalls upstream while a data access waits.
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   RegWriteE..RdE                  Execute outputs
//   stall                           hold Execute and earlier stages
//   dmem_req/we/addr/wdata          data-memory request side
//   dmem_rdata, dmem_ready          data-memory response side
//   pmem_we/addr/wdata              pixel-memory write port
//   io_we/wdata, io_rdata           IO port
//   bus_err                         one-cycle pulse on data-memory timeout
//   RegWriteW..RdW                  MEM/WB register
module mem_access_stage
  import hybrid_pkg::*;
#(
  parameter int unsigned DW      = 32,
  parameter int unsigned RW      = 4,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          RegWriteE,
  input  logic          MemWriteE,
  input  logic          MemPWriteE,
  input  logic          IOFlagE,
  input  logic [1:0]    MemToRegE,
  input  logic [DW-1:0] ALUResultE,
  input  logic [DW-1:0] WriteDataE,
  input  logic [RW-1:0] RdE,
  output logic          stall,
  output logic          dmem_req,
  output logic          dmem_we,
  output logic [DW-1:0] dmem_addr,
  output logic [DW-1:0] dmem_wdata,
  input  logic [DW-1:0] dmem_rdata,
  input  logic          dmem_ready,
  output logic          pmem_we,
  output logic [DW-1:0] pmem_addr,
  output logic [DW-1:0] pmem_wdata,
  output logic          io_we,
  output logic [DW-1:0] io_wdata,
  input  logic [DW-1:0] io_rdata,
  output logic          bus_err,
  output logic          RegWriteW,
  output logic [1:0]    MemToRegW,
  output logic [DW-1:0] ReadDataW,
  output logic [DW-1:0] ALUResultW,
  output logic [RW-1:0] RdW
);

  localparam int unsigned    CntW     = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CntW-1:0] TimeoutC = CntW'(TIMEOUT);

  // EX/MEM
  exmem_t        w_ctrl_e;
  exmem_t        w_ctrl;
  logic [DW-1:0] w_alu;
  logic [DW-1:0] w_wdata;
  logic [RW-1:0] w_rd;
  logic          w_capture;

  assign w_ctrl_e = '{
    reg_write:  RegWriteE,
    mem_write:  MemWriteE,
    mem_pwrite: MemPWriteE,
    io_flag:    IOFlagE,
    mem_to_reg: mem_to_reg_e'(MemToRegE)
  };

  exmem_reg #(
    .DW (DW),
    .RW (RW)
  ) u_exmem_reg (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_en    (w_capture),
    .i_ctrl  (w_ctrl_e),
    .i_alu   (ALUResultE),
    .i_wdata (WriteDataE),
    .i_rd    (RdE),
    .o_ctrl  (w_ctrl),
    .o_alu   (w_alu),
    .o_wdata (w_wdata),
    .o_rd    (w_rd)
  );

  // Classification of the latched op
  logic w_ld;
  logic w_st;
  logic w_dm;

  assign w_ld = is_load(w_ctrl);
  assign w_st = is_store(w_ctrl);
  assign w_dm = w_ld | w_st;

  // Access control
  mem_state_t      r_state;
  logic [CntW-1:0] r_cnt;
  logic            w_stall;
  logic            w_req;
  logic            w_timeout;

  // A completed access always coincides with stall = 0, so the next edge
  // latches a fresh op and the completed one can never re-request.
  always_comb begin
    w_stall   = 1'b0;
    w_req     = 1'b0;
    w_timeout = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_dm) begin
          w_req   = 1'b1;
          w_stall = ~dmem_ready;
        end
      end
      WAIT: begin
        // ready wins over a coincident timeout
        if (dmem_ready) begin
          w_req = 1'b1;
        end else if (r_cnt == TimeoutC) begin
          w_timeout = 1'b1;
        end else begin
          w_req   = 1'b1;
          w_stall = 1'b1;
        end
      end
    endcase
  end

  assign w_capture = ~w_stall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_dm && !dmem_ready) begin
            r_state <= WAIT;
            r_cnt   <= CntW'(1);
          end
        end
        WAIT: begin
          if (dmem_ready || (r_cnt == TimeoutC)) begin
            r_state <= IDLE;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + CntW'(1);
          end
        end
      endcase
    end
  end

  // MEM/WB
  logic          r_reg_write_w;
  logic [1:0]    r_mem_to_reg_w;
  logic [DW-1:0] r_read_data_w;
  logic [DW-1:0] r_alu_result_w;
  logic [RW-1:0] r_rd_w;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_reg_write_w  <= 1'b0;
      r_mem_to_reg_w <= '0;
      r_read_data_w  <= '0;
      r_alu_result_w <= '0;
      r_rd_w         <= '0;
    end else if (w_stall || w_timeout) begin
      // bubble: only the write enable is cleared
      r_reg_write_w <= 1'b0;
    end else begin
      r_reg_write_w  <= w_ctrl.reg_write;
      r_mem_to_reg_w <= w_ctrl.mem_to_reg;
      r_alu_result_w <= w_alu;
      r_rd_w         <= w_rd;
      if (w_ld) begin
        r_read_data_w <= dmem_rdata;
      end else if (w_ctrl.mem_to_reg == MTR_IO) begin
        r_read_data_w <= io_rdata;
      end
    end
  end

  // Outputs
  assign stall      = w_stall;
  assign dmem_req   = w_req;
  assign dmem_we    = w_req & w_st;
  assign dmem_addr  = w_alu;
  assign dmem_wdata = w_wdata;

  // Side-effect strobes fire on the op's single non-stalled cycle.
  assign pmem_we    = w_ctrl.mem_pwrite & ~w_stall;
  assign pmem_addr  = w_alu;
  assign pmem_wdata = w_wdata;
  assign io_we      = w_ctrl.mem_write & w_ctrl.io_flag & ~w_stall;
  assign io_wdata   = w_wdata;

  assign bus_err    = w_timeout;

  assign RegWriteW  = r_reg_write_w;
  assign MemToRegW  = r_mem_to_reg_w;
  assign ReadDataW  = r_read_data_w;
  assign ALUResultW = r_alu_result_w;
  assign RdW        = r_rd_w;

endmodule

// File: tb/tb_mem_access_stage.sv
module tb_mem_access_stage;

  localparam int DW = 32;
  localparam int RW = 4;
  localparam int TO = 15;

  typedef struct packed {
    logic        rw;
    logic        mw;
    logic        pw;
    logic        io;
    logic [1:0]  mtr;
    logic [31:0] alu;
    logic [31:0] wd;
    logic [3:0]  rd;
  } op_t;

  logic          clk        = 1'b0;
  logic          rst_n      = 1'b0;
  logic          RegWriteE  = 1'b0;
  logic          MemWriteE  = 1'b0;
  logic          MemPWriteE = 1'b0;
  logic          IOFlagE    = 1'b0;
  logic [1:0]    MemToRegE  = 2'b00;
  logic [DW-1:0] ALUResultE = '0;
  logic [DW-1:0] WriteDataE = '0;
  logic [RW-1:0] RdE        = '0;
  logic [DW-1:0] dmem_rdata = '0;
  logic          dmem_ready = 1'b0;
  logic [DW-1:0] io_rdata   = '0;

  logic          stall;
  logic          dmem_req;
  logic          dmem_we;
  logic [DW-1:0] dmem_addr;
  logic [DW-1:0] dmem_wdata;
  logic          pmem_we;
  logic [DW-1:0] pmem_addr;
  logic [DW-1:0] pmem_wdata;
  logic          io_we;
  logic [DW-1:0] io_wdata;
  logic          bus_err;
  logic          RegWriteW;
  logic [1:0]    MemToRegW;
  logic [DW-1:0] ReadDataW;
  logic [DW-1:0] ALUResultW;
  logic [RW-1:0] RdW;

  mem_access_stage #(
    .DW      (DW),
    .RW      (RW),
    .TIMEOUT (TO)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .RegWriteE  (RegWriteE),
    .MemWriteE  (MemWriteE),
    .MemPWriteE (MemPWriteE),
    .IOFlagE    (IOFlagE),
    .MemToRegE  (MemToRegE),
    .ALUResultE (ALUResultE),
    .WriteDataE (WriteDataE),
    .RdE        (RdE),
    .stall      (stall),
    .dmem_req   (dmem_req),
    .dmem_we    (dmem_we),
    .dmem_addr  (dmem_addr),
    .dmem_wdata (dmem_wdata),
    .dmem_rdata (dmem_rdata),
    .dmem_ready (dmem_ready),
    .pmem_we    (pmem_we),
    .pmem_addr  (pmem_addr),
    .pmem_wdata (pmem_wdata),
    .io_we      (io_we),
    .io_wdata   (io_wdata),
    .io_rdata   (io_rdata),
    .bus_err    (bus_err),
    .RegWriteW  (RegWriteW),
    .MemToRegW  (MemToRegW),
    .ReadDataW  (ReadDataW),
    .ALUResultW (ALUResultW),
    .RdW        (RdW)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Expected MEM/WB contents
  logic        m_rw;
  logic [1:0]  m_mtr;
  logic [31:0] m_alu;
  logic [31:0] m_rdata;
  logic [3:0]  m_rd;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    total++;
    assert (obs === want) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, want);
    end
  endtask

  task automatic model_reset();
    m_rw    = 1'b0;
    m_mtr   = 2'b00;
    m_alu   = '0;
    m_rdata = '0;
    m_rd    = '0;
  endtask

  task automatic drive_e(input op_t o);
    RegWriteE  = o.rw;
    MemWriteE  = o.mw;
    MemPWriteE = o.pw;
    IOFlagE    = o.io;
    MemToRegE  = o.mtr;
    ALUResultE = o.alu;
    WriteDataE = o.wd;
    RdE        = o.rd;
  endtask

  function automatic op_t rand_op();
    op_t o;
    o.rw  = 1'($urandom);
    o.mw  = 1'($urandom);
    o.pw  = 1'($urandom);
    o.io  = ($urandom_range(0, 3) == 0);
    o.mtr = 2'($urandom);
    o.alu = $urandom;
    o.wd  = $urandom;
    o.rd  = 4'($urandom);
    return o;
  endfunction

  task automatic chk_wb(input string tag);
    chk({tag, ".RegWriteW"},  32'(RegWriteW),  32'(m_rw));
    chk({tag, ".MemToRegW"},  32'(MemToRegW),  32'(m_mtr));
    chk({tag, ".ALUResultW"}, ALUResultW,      m_alu);
    chk({tag, ".RdW"},        32'(RdW),        32'(m_rd));
    chk({tag, ".ReadDataW"},  ReadDataW,       m_rdata);
  endtask

  // Runs one op through the stage. Entered just after a rising edge with a
  // bubble latched; returns just after the edge that retires the op.
  // ready_at: cycle (0 = same cycle as the request) at which dmem_ready is
  // raised for one cycle; anything outside 0..TO means it never arrives.
  task automatic run_op(input string tag, input op_t o, input int ready_at,
                        input logic [31:0] rdata, input logic [31:0] iodata);
    op_t zero;
    bit  ld, st, dm, tmo, fin;
    int  last;
    zero = '0;
    ld   = o.rw && (o.mtr == 2'b00) && !o.io;
    st   = o.mw && !o.io;
    dm   = ld || st;
    if (!dm) begin
      last = 0;
      tmo  = 1'b0;
    end else if (ready_at >= 0 && ready_at <= TO) begin
      last = ready_at;
      tmo  = 1'b0;
    end else begin
      last = TO;
      tmo  = 1'b1;
    end

    drive_e(o);
    dmem_ready = 1'b0;
    io_rdata   = iodata;
    @(negedge clk);
    chk({tag, ".pre.stall"}, 32'(stall), 32'(0));
    chk({tag, ".pre.req"},   32'(dmem_req), 32'(0));
    chk_wb({tag, ".pre"});
    @(posedge clk);
    #1;
    // the edge that latches this op retires the preceding bubble
    m_rw  = 1'b0;
    m_mtr = 2'b00;
    m_alu = '0;
    m_rd  = '0;

    for (int c = 0; c <= last; c++) begin
      fin        = (c == last);
      dmem_ready = (c == ready_at);
      dmem_rdata = (c == ready_at) ? rdata : $urandom;
      // junk on the Execute side while stalled must not disturb the op
      if (fin) drive_e(zero);
      else     drive_e(rand_op());
      @(negedge clk);
      chk({tag, ".stall"},   32'(stall),    32'(dm && !fin));
      chk({tag, ".req"},     32'(dmem_req), 32'(dm && !(tmo && fin)));
      chk({tag, ".we"},      32'(dmem_we),  32'(st && !(tmo && fin)));
      chk({tag, ".bus_err"}, 32'(bus_err),  32'(tmo && fin));
      chk({tag, ".pmem_we"}, 32'(pmem_we),  32'(o.pw && fin));
      chk({tag, ".io_we"},   32'(io_we),    32'(o.mw && o.io && fin));
      if (dm) begin
        chk({tag, ".addr"},  dmem_addr,  o.alu);
        chk({tag, ".wdata"}, dmem_wdata, o.wd);
      end
      if (o.pw && fin) begin
        chk({tag, ".pmem_addr"},  pmem_addr,  o.alu);
        chk({tag, ".pmem_wdata"}, pmem_wdata, o.wd);
      end
      if (o.mw && o.io && fin) chk({tag, ".io_wdata"}, io_wdata, o.wd);
      chk_wb(tag);
      @(posedge clk);
      #1;
      if (!fin || tmo) begin
        m_rw = 1'b0;
      end else begin
        m_rw  = o.rw;
        m_mtr = o.mtr;
        m_alu = o.alu;
        m_rd  = o.rd;
        if (ld)                 m_rdata = rdata;
        else if (o.mtr == 2'b10) m_rdata = iodata;
      end
    end
    dmem_ready = 1'b0;
  endtask

  initial begin
    op_t o;
    int  r;
    int  ra;
    model_reset();

    // Reset state
    #2;
    chk("rst.stall",     32'(stall),     32'(0));
    chk("rst.req",       32'(dmem_req),  32'(0));
    chk("rst.pmem_we",   32'(pmem_we),   32'(0));
    chk("rst.io_we",     32'(io_we),     32'(0));
    chk("rst.bus_err",   32'(bus_err),   32'(0));
    chk("rst.dmem_addr", dmem_addr,      32'(0));
    chk_wb("rst");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 1: ALU op
    o = '0; o.rw = 1'b1; o.mtr = 2'b01; o.alu = 32'h15; o.rd = 4'd3;
    run_op("alu", o, 0, 32'h0, 32'h0);

    // 2: load with two wait cycles
    o = '0; o.rw = 1'b1; o.mtr = 2'b00; o.alu = 32'h100; o.rd = 4'd5;
    run_op("ld_wait2", o, 2, 32'hDEADBEEF, 32'h0);

    // 3: zero-wait store
    o = '0; o.mw = 1'b1; o.alu = 32'h40; o.wd = 32'hF0;
    run_op("st_zw", o, 0, 32'h0, 32'h0);

    // 4: load that never gets ready
    o = '0; o.rw = 1'b1; o.alu = 32'h200; o.rd = 4'd7;
    run_op("ld_tmo", o, -1, 32'h0, 32'h0);

    // ready on the very last permitted cycle beats the timeout
    o = '0; o.rw = 1'b1; o.alu = 32'h204; o.rd = 4'd8;
    run_op("ld_edge", o, TO, 32'hCAFEF00D, 32'h0);

    // 5: pixel write plus IO store
    o = '0; o.mw = 1'b1; o.pw = 1'b1; o.io = 1'b1; o.alu = 32'h80; o.wd = 32'h1234;
    run_op("pix_io", o, 0, 32'h0, 32'h0);

    // IO read
    o = '0; o.rw = 1'b1; o.io = 1'b1; o.mtr = 2'b10; o.alu = 32'h300; o.rd = 4'd9;
    run_op("io_rd", o, 0, 32'h0, 32'h5A5A1234);

    // 6: reset while waiting on a load
    o = '0; o.rw = 1'b1; o.alu = 32'h400; o.rd = 4'd2;
    drive_e(o);
    dmem_ready = 1'b0;
    @(posedge clk);
    #1;
    drive_e('0);
    @(posedge clk);
    #1;
    chk("rstwait.pre.req",   32'(dmem_req), 32'(1));
    chk("rstwait.pre.stall", 32'(stall),    32'(1));
    #2;
    rst_n = 1'b0;
    #1;
    chk("rstwait.req",       32'(dmem_req),  32'(0));
    chk("rstwait.stall",     32'(stall),     32'(0));
    chk("rstwait.bus_err",   32'(bus_err),   32'(0));
    chk("rstwait.RegWriteW", 32'(RegWriteW), 32'(0));
    chk("rstwait.dmem_addr", dmem_addr,      32'(0));
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    o = '0; o.rw = 1'b1; o.alu = 32'h404; o.rd = 4'd4;
    run_op("ld_after_rst", o, 1, 32'h13572468, 32'h0);

    // Randomized ops
    for (int i = 0; i < 40; i++) begin
      o = rand_op();
      r = $urandom_range(0, 9);
      if (r < 5)       ra = 0;
      else if (r < 8)  ra = $urandom_range(1, 4);
      else if (r == 8) ra = $urandom_range(5, TO);
      else             ra = -1;
      run_op("rand", o, ra, $urandom, $urandom);
    end

    @(negedge clk);
    chk_wb("final");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
